// File: rtl/regfile_write_buffer_if.sv
// -----------------------------------------------------------------------------
// regfile_write_buffer_if
//   Bundles the signals between the register-file write buffer and the rest of
//   the datapath.
//     request side : req_valid/req_ready handshake carrying req_rd/req_data
//     drain side   : RegWrite/RD/WriteData towards the register file write port
//     forward side : RS1/RS2 operand addresses in, fwdN_hit/fwdN_data out
//     control      : hold (freeze draining)
//     status       : count/empty/full
//   modport master : the producer/datapath side that drives requests and reads
//   modport slave  : the write buffer itself
// -----------------------------------------------------------------------------
interface regfile_write_buffer_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int AW    = 5
);
    localparam int CW = $clog2(DEPTH) + 1;

    // request handshake
    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   req_rd;
    logic [XLEN-1:0] req_data;

    // drain control
    logic            hold;

    // operand forwarding
    logic [AW-1:0]   RS1;
    logic [AW-1:0]   RS2;
    logic            fwd1_hit;
    logic [XLEN-1:0] fwd1_data;
    logic            fwd2_hit;
    logic [XLEN-1:0] fwd2_data;

    // register file write port
    logic            RegWrite;
    logic [AW-1:0]   RD;
    logic [XLEN-1:0] WriteData;

    // occupancy status
    logic [CW-1:0]   count;
    logic            empty;
    logic            full;

    modport master (
        output req_valid, req_rd, req_data, hold, RS1, RS2,
        input  req_ready, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data,
        input  RegWrite, RD, WriteData, count, empty, full
    );

    modport slave (
        input  req_valid, req_rd, req_data, hold, RS1, RS2,
        output req_ready, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data,
        output RegWrite, RD, WriteData, count, empty, full
    );
endinterface

// File: rtl/regfile_write_buffer.sv
// -----------------------------------------------------------------------------
// regfile_write_buffer
//   Writer-side front end of the 32 x XLEN register file. Writeback requests
//   are queued in a small in-order circular FIFO and drained at most one per
//   clock onto the register-file write port. Pending data is forwarded to the
//   two operand read addresses so the datapath always sees the youngest value.
//
//   Ports
//     clk    : rising-edge clock
//     reset  : synchronous, active-high reset (pointers/count cleared, all
//              outputs forced to their idle values while asserted)
//     bus    : regfile_write_buffer_if.slave (request, drain, forward, status)
//
//   Parameters
//     DEPTH  : number of buffered entries, power of two, at least 2
//     XLEN   : data width, must match the register file
//     AW     : register address width
// -----------------------------------------------------------------------------
module regfile_write_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int AW    = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_write_buffer_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_FULL  = CW'(DEPTH);
    localparam logic [PW-1:0]   PTR_ZERO  = {PW{1'b0}};
    localparam logic [AW-1:0]   RD_ZERO   = {AW{1'b0}};
    localparam logic [XLEN-1:0] DATA_ZERO = {XLEN{1'b0}};

    // Advance a FIFO pointer; DEPTH is a power of two so wrap is free.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return ptr + {{(PW-1){1'b0}}, 1'b1};
    endfunction

    // Entry storage. Validity is implied by head/count, so the arrays need
    // no reset.
    logic [AW-1:0]   rd_mem_r   [DEPTH];
    logic [XLEN-1:0] data_mem_r [DEPTH];

    logic [PW-1:0]   head_r;
    logic [PW-1:0]   tail_r;
    logic [CW-1:0]   count_r;

    logic [PW-1:0]   head_nxt_s;
    logic [PW-1:0]   tail_nxt_s;
    logic [CW-1:0]   count_nxt_s;

    logic            empty_s;
    logic            full_s;
    logic            ready_s;
    logic            push_s;
    logic            pop_s;

    logic [AW-1:0]   drain_rd_s;
    logic [XLEN-1:0] drain_data_s;

    logic            fwd1_hit_s;
    logic [XLEN-1:0] fwd1_data_s;
    logic            fwd2_hit_s;
    logic [XLEN-1:0] fwd2_data_s;
    logic [PW-1:0]   idx_s;
    logic            valid_s;
    logic            match1_s;
    logic            match2_s;

    // Occupancy flags and the push/pop decisions for this edge.
    always_comb begin
        empty_s = (count_r == CNT_ZERO);
        full_s  = (count_r == CNT_FULL);
        // Ready depends only on registered occupancy, never on req_valid.
        ready_s = !full_s;
        // x0 writes are acknowledged but never stored; reset blocks accepts.
        push_s  = bus.req_valid && ready_s && !reset && (bus.req_rd != RD_ZERO);
        // Draining is gated by hold and suppressed for the whole reset cycle.
        pop_s   = !empty_s && !bus.hold && !reset;
    end

    // Next pointer and occupancy values.
    always_comb begin
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;

        if (pop_s) begin
            head_nxt_s = ptr_inc(head_r);
        end else begin
            head_nxt_s = head_r;
        end

        if (push_s) begin
            tail_nxt_s = ptr_inc(tail_r);
        end else begin
            tail_nxt_s = tail_r;
        end

        // Simultaneous push and pop leaves the count unchanged.
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else begin
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Write an accepted request into the tail slot.
    always_ff @(posedge clk) begin
        if (push_s) begin
            rd_mem_r[tail_r]   <= bus.req_rd;
            data_mem_r[tail_r] <= bus.req_data;
        end
    end

    // Present the head entry on the drain port, zero when nothing is pending.
    always_comb begin
        drain_rd_s   = RD_ZERO;
        drain_data_s = DATA_ZERO;
        if (!empty_s && !reset) begin
            drain_rd_s   = rd_mem_r[head_r];
            drain_data_s = data_mem_r[head_r];
        end else begin
            drain_rd_s   = RD_ZERO;
            drain_data_s = DATA_ZERO;
        end
    end

    // Forwarding search from oldest to youngest so a later match overrides an
    // earlier one; the head entry being drained this cycle is still searched.
    always_comb begin
        fwd1_hit_s  = 1'b0;
        fwd1_data_s = DATA_ZERO;
        fwd2_hit_s  = 1'b0;
        fwd2_data_s = DATA_ZERO;
        idx_s       = head_r;
        valid_s     = 1'b0;
        match1_s    = 1'b0;
        match2_s    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s    = head_r + PW'(i);
            valid_s  = (CW'(i) < count_r) && !reset;
            match1_s = valid_s && (bus.RS1 != RD_ZERO) && (rd_mem_r[idx_s] == bus.RS1);
            match2_s = valid_s && (bus.RS2 != RD_ZERO) && (rd_mem_r[idx_s] == bus.RS2);
            fwd1_hit_s  = fwd1_hit_s | match1_s;
            fwd1_data_s = match1_s ? data_mem_r[idx_s] : fwd1_data_s;
            fwd2_hit_s  = fwd2_hit_s | match2_s;
            fwd2_data_s = match2_s ? data_mem_r[idx_s] : fwd2_data_s;
        end
    end

    // Interface outputs; reset forces the idle view during the reset cycle.
    assign bus.req_ready = reset | ready_s;
    assign bus.RegWrite  = pop_s;
    assign bus.RD        = drain_rd_s;
    assign bus.WriteData = drain_data_s;
    assign bus.fwd1_hit  = fwd1_hit_s;
    assign bus.fwd1_data = fwd1_data_s;
    assign bus.fwd2_hit  = fwd2_hit_s;
    assign bus.fwd2_data = fwd2_data_s;
    assign bus.count     = reset ? CNT_ZERO : count_r;
    assign bus.empty     = reset | empty_s;
    assign bus.full      = !reset & full_s;

endmodule

// File: tb/tb_regfile_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_buffer
//   Directed self-checking bench for regfile_write_buffer (DEPTH=4, XLEN=64,
//   AW=5). Commits seen on the write port are logged and compared with the
//   expected commit order at the end of each scenario.
// -----------------------------------------------------------------------------
module tb_regfile_write_buffer;

    logic clk;
    logic reset;

    int total = 0;
    int bad   = 0;

    regfile_write_buffer_if #(.DEPTH(4), .XLEN(64), .AW(5)) bus ();

    regfile_write_buffer #(.DEPTH(4), .XLEN(64), .AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // committed and expected writes as {rd, data}
    logic [68:0] commit_q [$];
    logic [68:0] exp_q    [$];
    // reference FIFO for the wrap-around scenario
    logic [68:0] mq       [$];

    // log every commit the register file would take at this edge
    always @(posedge clk) begin
        if (bus.RegWrite === 1'b1) begin
            commit_q.push_back({bus.RD, bus.WriteData});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [4:0] rd, input logic [63:0] d);
        bus.req_valid = 1'b1;
        bus.req_rd    = rd;
        bus.req_data  = d;
    endtask

    // compare commit log with expected list, then clear both
    task automatic check_commits(input string tag);
        int n;
        check({tag, "_n"}, 64'(commit_q.size()), 64'(exp_q.size()));
        n = (commit_q.size() < exp_q.size()) ? commit_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_rd"},   64'(commit_q[i][68:64]), 64'(exp_q[i][68:64]));
            check({tag, "_data"}, commit_q[i][63:0],       exp_q[i][63:0]);
        end
        commit_q.delete();
        exp_q.delete();
    endtask

    // one modelled cycle: drive, compare against the reference FIFO, advance
    task automatic step(input logic v, input logic [4:0] rd, input logic [63:0] d, input logic h);
        logic        exp_rw;
        logic        exp_ready;
        logic [68:0] hd;
        bus.req_valid = v;
        bus.req_rd    = rd;
        bus.req_data  = d;
        bus.hold      = h;
        #1;
        exp_ready = (mq.size() < 4);
        exp_rw    = (mq.size() > 0) && !h;
        hd        = (mq.size() > 0) ? mq[0] : 69'd0;
        check("w_ready",    64'(bus.req_ready), 64'(exp_ready));
        check("w_count",    64'(bus.count),     64'(mq.size()));
        check("w_cnt_le",   64'(bus.count <= 3'd4), 64'd1);
        check("w_regwrite", 64'(bus.RegWrite),  64'(exp_rw));
        check("w_rd",       64'(bus.RD),        64'(hd[68:64]));
        check("w_data",     bus.WriteData,      hd[63:0]);
        if (exp_rw) begin
            exp_q.push_back(mq.pop_front());
        end
        if (v && exp_ready && (rd != 5'd0)) begin
            mq.push_back({rd, d});
        end
        tick();
        bus.req_valid = 1'b0;
    endtask

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic [63:0] d;
        logic        h;
    } op_t;

    op_t ops [10];

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_rd    = 5'd0;
        bus.req_data  = 64'd0;
        bus.hold      = 1'b0;
        bus.RS1       = 5'd0;
        bus.RS2       = 5'd0;
        tick();

        // ---- reset state, request presented during reset is ignored ----
        push_req(5'd5, 64'h55);
        #1;
        check("rst_regwrite", 64'(bus.RegWrite),  64'd0);
        check("rst_ready",    64'(bus.req_ready), 64'd1);
        check("rst_empty",    64'(bus.empty),     64'd1);
        check("rst_full",     64'(bus.full),      64'd0);
        check("rst_count",    64'(bus.count),     64'd0);
        tick();
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("rst_count_after", 64'(bus.count), 64'd0);
        check("rst_empty_after", 64'(bus.empty), 64'd1);
        tick();
        check_commits("rst_commits");

        // ---- single write ----
        push_req(5'd12, 64'hAB);
        #1;
        check("single_ready", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 1'b0;
        #1;
        check("single_regwrite", 64'(bus.RegWrite), 64'd1);
        check("single_rd",       64'(bus.RD),       64'd12);
        check("single_data",     bus.WriteData,     64'hAB);
        check("single_count",    64'(bus.count),    64'd1);
        tick();
        check("single_empty",    64'(bus.empty),    64'd1);
        check("single_count0",   64'(bus.count),    64'd0);
        check("single_rw0",      64'(bus.RegWrite), 64'd0);
        exp_q.push_back({5'd12, 64'hAB});
        check_commits("single_commits");

        // ---- fill and backpressure ----
        bus.hold = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            push_req(5'(k), 64'(k * 16));
            tick();
        end
        push_req(5'd5, 64'h50);
        #1;
        check("fill_count", 64'(bus.count),     64'd4);
        check("fill_full",  64'(bus.full),      64'd1);
        check("fill_ready", 64'(bus.req_ready), 64'd0);
        check("fill_hold",  64'(bus.RegWrite),  64'd0);
        tick();
        check("fill_5th_refused", 64'(bus.count), 64'd4);
        bus.hold = 1'b0;
        push_req(5'd6, 64'h60);
        #1;
        check("drain1_rw",    64'(bus.RegWrite),  64'd1);
        check("drain1_rd",    64'(bus.RD),        64'd1);
        check("drain1_data",  bus.WriteData,      64'h10);
        check("drain1_ready", 64'(bus.req_ready), 64'd0);
        tick();
        bus.req_valid = 1'b0;
        #1;
        check("drain2_count", 64'(bus.count),     64'd3);
        check("drain2_ready", 64'(bus.req_ready), 64'd1);
        check("drain2_rd",    64'(bus.RD),        64'd2);
        tick();
        check("drain3_rd",    64'(bus.RD),        64'd3);
        tick();
        check("drain4_rd",    64'(bus.RD),        64'd4);
        check("drain4_count", 64'(bus.count),     64'd1);
        tick();
        check("drain_empty",  64'(bus.empty),     64'd1);
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back({5'(k), 64'(k * 16)});
        end
        check_commits("fill_commits");

        // ---- forwarding priority ----
        bus.hold = 1'b1;
        push_req(5'd13, 64'h111);
        tick();
        push_req(5'd13, 64'h222);
        bus.RS1 = 5'd13;
        #1;
        check("fwd_notyet_data", bus.fwd1_data, 64'h111);
        tick();
        bus.req_valid = 1'b0;
        bus.RS1 = 5'd13;
        bus.RS2 = 5'd14;
        #1;
        check("fwd1_hit",   64'(bus.fwd1_hit), 64'd1);
        check("fwd1_data",  bus.fwd1_data,     64'h222);
        check("fwd2_miss",  64'(bus.fwd2_hit), 64'd0);
        check("fwd2_zero",  bus.fwd2_data,     64'd0);
        bus.RS2 = 5'd13;
        bus.RS1 = 5'd0;
        #1;
        check("fwd2_hit",   64'(bus.fwd2_hit), 64'd1);
        check("fwd2_data",  bus.fwd2_data,     64'h222);
        check("fwd_x0_hit", 64'(bus.fwd1_hit), 64'd0);
        check("fwd_x0_data", bus.fwd1_data,    64'd0);
        bus.hold = 1'b0;
        tick();
        tick();
        check("fwd_empty",  64'(bus.empty), 64'd1);
        bus.RS2 = 5'd0;
        exp_q.push_back({5'd13, 64'h111});
        exp_q.push_back({5'd13, 64'h222});
        check_commits("fwd_commits");

        // ---- x0 drop ----
        push_req(5'd0, 64'hFFFF);
        #1;
        check("x0_ready_pre", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 1'b0;
        #1;
        check("x0_count", 64'(bus.count),     64'd0);
        check("x0_rw",    64'(bus.RegWrite),  64'd0);
        check("x0_ready", 64'(bus.req_ready), 64'd1);
        tick();
        check("x0_rw2",   64'(bus.RegWrite),  64'd0);
        check_commits("x0_commits");

        // ---- wrap-around against reference FIFO ----
        ops[0] = '{1'b1, 5'd3,  64'hA1, 1'b1};
        ops[1] = '{1'b1, 5'd7,  64'hA2, 1'b1};
        ops[2] = '{1'b1, 5'd3,  64'hA3, 1'b0};
        ops[3] = '{1'b0, 5'd0,  64'h0,  1'b0};
        ops[4] = '{1'b1, 5'd9,  64'hA4, 1'b1};
        ops[5] = '{1'b1, 5'd10, 64'hA5, 1'b1};
        ops[6] = '{1'b1, 5'd11, 64'hA6, 1'b1};
        ops[7] = '{1'b1, 5'd0,  64'hA7, 1'b0};
        ops[8] = '{1'b1, 5'd12, 64'hA8, 1'b0};
        ops[9] = '{1'b1, 5'd13, 64'hA9, 1'b1};
        for (int i = 0; i < 10; i++) begin
            step(ops[i].v, ops[i].rd, ops[i].d, ops[i].h);
        end
        step(1'b1, 5'd14, 64'hAA, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 5'd0, 64'd0, 1'b0);
        end
        check("wrap_model_empty", 64'(mq.size()), 64'd0);
        check_commits("wrap_commits");

        // ---- reset mid-operation ----
        bus.hold = 1'b1;
        push_req(5'd21, 64'h2100);
        tick();
        push_req(5'd22, 64'h2200);
        tick();
        push_req(5'd23, 64'h2300);
        tick();
        bus.req_valid = 1'b0;
        #1;
        check("mid_count3", 64'(bus.count), 64'd3);
        reset    = 1'b1;
        bus.hold = 1'b0;
        bus.RS1  = 5'd22;
        push_req(5'd24, 64'h2400);
        #1;
        check("mid_rw",       64'(bus.RegWrite),  64'd0);
        check("mid_rd",       64'(bus.RD),        64'd0);
        check("mid_data",     bus.WriteData,      64'd0);
        check("mid_ready",    64'(bus.req_ready), 64'd1);
        check("mid_count",    64'(bus.count),     64'd0);
        check("mid_empty",    64'(bus.empty),     64'd1);
        check("mid_fwd_hit",  64'(bus.fwd1_hit),  64'd0);
        check("mid_fwd_data", bus.fwd1_data,      64'd0);
        tick();
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("mid_count_after", 64'(bus.count),    64'd0);
        check("mid_rw_after",    64'(bus.RegWrite), 64'd0);
        check("mid_fwd_after",   64'(bus.fwd1_hit), 64'd0);
        tick();
        tick();
        check_commits("mid_commits");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
